// File: rtl/frame_stream_gen.sv
// Test-pattern pixel stream source: frames of h_pixel x v_pixel pixels with line/frame blanking,
// valid/ready backpressure and hstart/fstart/hend/fend framing flags.
module frame_stream_gen #(
  parameter int DATA_W = 16,
  parameter int HBLANK = 8,
  parameter int VBLANK = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       h_pixel,
  input  logic [15:0]       v_pixel,
  input  logic [1:0]        pattern_sel,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              hstart,
  output logic              fstart,
  output logic              hend,
  output logic              fend,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a pixel moves on a rising clk edge where out_valid && out_ready; while
  // out_ready is low the presented pixel, its flags and the x/y position hold unchanged.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLK   = 2'd2,
    VBLK   = 2'd3
  } state_t;

  localparam logic [15:0] HB_LOAD = 16'(HBLANK - 1);
  localparam logic [15:0] VB_LOAD = 16'(VBLANK - 1);

  state_t            state;
  logic [15:0]       x;
  logic [15:0]       y;
  logic [15:0]       hl;
  logic [15:0]       vl;
  logic [15:0]       frame_cnt;
  logic [15:0]       bcnt;
  logic [1:0]        pat;
  logic              start_ok;
  logic              last_x;
  logic              last_y;
  logic [DATA_W-1:0] pix;

  assign start_ok = enable && (h_pixel != 16'd0) && (v_pixel != 16'd0);
  assign last_x   = (x == hl - 16'd1);
  assign last_y   = (y == vl - 16'd1);

  always_comb begin
    pix = '0;
    case (pat)
      2'd0: pix = DATA_W'(x);
      2'd1: pix = DATA_W'(y);
      2'd2: pix = (x[3] ^ y[3]) ? '1 : '0;
      2'd3: pix = DATA_W'(16'(x + frame_cnt));
    endcase
  end

  // Outputs are decodes of registered state only, so reset clears them asynchronously.
  assign out_valid = (state == ACTIVE);
  assign busy      = (state != IDLE);
  assign hstart    = out_valid && (x == 16'd0);
  assign fstart    = hstart && (y == 16'd0);
  assign hend      = out_valid && last_x;
  assign fend      = hend && last_y;
  assign out_data  = out_valid ? pix : '0;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      hl        <= '0;
      vl        <= '0;
      pat       <= '0;
      frame_cnt <= '0;
      bcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            hl    <= h_pixel;
            vl    <= v_pixel;
            pat   <= pattern_sel;
            x     <= '0;
            y     <= '0;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (out_ready) begin
            if (!last_x) begin
              x <= x + 16'd1;
            end else if (!last_y) begin
              x <= '0;
              y <= y + 16'd1;
              if (HBLANK != 0) begin
                bcnt  <= HB_LOAD;
                state <= HBLK;
              end
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
              if (VBLANK != 0) begin
                bcnt  <= VB_LOAD;
                state <= VBLK;
              end else if (start_ok) begin
                // Zero vertical blanking: the frame boundary is this very edge.
                hl  <= h_pixel;
                vl  <= v_pixel;
                pat <= pattern_sel;
                x   <= '0;
                y   <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        HBLK: begin
          if (bcnt == 16'd0) state <= ACTIVE;
          else               bcnt  <= bcnt - 16'd1;
        end
        VBLK: begin
          if (bcnt != 16'd0) begin
            bcnt <= bcnt - 16'd1;
          end else if (start_ok) begin
            hl    <= h_pixel;
            vl    <= v_pixel;
            pat   <= pattern_sel;
            x     <= '0;
            y     <= '0;
            state <= ACTIVE;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
